// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Bus initiator for a synchronous single-port RAM. Arbitrates
//               between an instruction-fetch requester (read-only) and a
//               data load/store requester. Each request gets exactly one RAM
//               operation. The RAM's one-cycle registered read latency is
//               absorbed here, and data returns with a done pulse.
//
// Ports       : clk        system clock, all state on rising edge
//               clr_n      asynchronous active-low reset
//               if_req     fetch request, held until if_gnt
//               if_addr    fetch word address (32 bit)
//               if_gnt     1-cycle pulse, fetch accepted
//               if_done    1-cycle pulse, fetch data valid on rdata
//               d_req      data request, held until d_gnt
//               d_we       1 = store, 0 = load
//               d_addr     data word address (32 bit)
//               d_wdata    store data
//               d_gnt      1-cycle pulse, data request accepted
//               d_done     1-cycle pulse, load data valid / store committed
//               rdata      read data, held until the next done
//               err        address out of range, valid with done
//               busy       high whenever the controller is not idle
//               ram_addr   RAM address
//               ram_wdata  RAM write data
//               ram_we     RAM write enable
//               ram_re     RAM read enable
//               ram_rdata  RAM registered read data
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ISSUE_W = 3'd1;
    localparam logic [2:0] c_ISSUE_R = 3'd2;
    localparam logic [2:0] c_WAIT_R  = 3'd3;
    localparam logic [2:0] c_ERR     = 3'd4;

    logic [2:0]        r_state;
    logic              r_rr_last_d;   // 1: last grant went to the data requester
    logic              r_cur_fetch;   // requester owning the operation in flight
    logic              r_if_gnt;
    logic              r_if_done;
    logic              r_d_gnt;
    logic              r_d_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_busy;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_ram_we;
    logic              r_ram_re;

    logic              w_grant_if;
    logic              w_grant_d;
    logic [31:0]       w_sel_addr;
    logic              w_sel_we;
    logic              w_oor;

    // Round robin: on contention the requester not granted last wins.
    assign w_grant_if = if_req && (!d_req || r_rr_last_d);
    assign w_grant_d  = d_req && (!if_req || !r_rr_last_d);

    // Fetch never writes, so d_we only matters when data wins.
    assign w_sel_addr = w_grant_if ? if_addr : d_addr;
    assign w_sel_we   = w_grant_d && d_we;
    assign w_oor      = |w_sel_addr[31:ADDR_W];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= c_IDLE;
            r_rr_last_d <= 1'b1;
            r_cur_fetch <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_if_done   <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_d_done    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_ram_re    <= 1'b0;
        end else begin
            // Pulses and strobes last exactly one cycle unless re-asserted.
            r_if_gnt  <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_ram_re  <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_grant_if || w_grant_d) begin
                        r_if_gnt    <= w_grant_if;
                        r_d_gnt     <= w_grant_d;
                        r_rr_last_d <= w_grant_d;
                        r_cur_fetch <= w_grant_if;
                        r_busy      <= 1'b1;
                        if (w_oor) begin
                            // Out-of-range: no RAM strobe, RAM bus keeps its value.
                            r_state <= c_ERR;
                        end else begin
                            r_ram_addr <= w_sel_addr[ADDR_W-1:0];
                            if (w_sel_we) begin
                                r_ram_we    <= 1'b1;
                                r_ram_wdata <= d_wdata;
                                r_state     <= c_ISSUE_W;
                            end else begin
                                r_ram_re <= 1'b1;
                                r_state  <= c_ISSUE_R;
                            end
                        end
                    end
                end

                c_ISSUE_W: begin
                    // RAM commits the write on this edge.
                    r_state  <= c_IDLE;
                    r_busy   <= 1'b0;
                    r_d_done <= 1'b1;
                    r_err    <= 1'b0;
                end

                c_ISSUE_R: begin
                    // RAM registers its output on this edge; capture next cycle.
                    r_state <= c_WAIT_R;
                end

                c_WAIT_R: begin
                    r_state   <= c_IDLE;
                    r_busy    <= 1'b0;
                    r_rdata   <= ram_rdata;
                    r_err     <= 1'b0;
                    r_if_done <= r_cur_fetch;
                    r_d_done  <= !r_cur_fetch;
                end

                c_ERR: begin
                    r_state   <= c_IDLE;
                    r_busy    <= 1'b0;
                    r_rdata   <= '0;
                    r_err     <= 1'b1;
                    r_if_done <= r_cur_fetch;
                    r_d_done  <= !r_cur_fetch;
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_done   = r_if_done;
    assign d_gnt     = r_d_gnt;
    assign d_done    = r_d_done;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign busy      = r_busy;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign ram_re    = r_ram_re;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a synchronous
//               RAM model, a reference memory and an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_done;
    logic [31:0] rdata;
    logic        err, busy;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we, ram_re;
    logic [31:0] ram_rdata = '0;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .clr_n(clr_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done),
        .rdata(rdata), .err(err), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with registered read data
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        bit          fetch;
        bit          err;
        bit          chk_data;
        logic [31:0] data;
        int          lat;
    } sb_t;

    sb_t sb[$];
    int  gq[$];
    int  gnt_log[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  we_cnt = 0, re_cnt = 0, both_cnt = 0, dd_cnt = 0;
    logic [7:0]  last_we_addr = '0;
    logic [31:0] last_we_data = '0;
    bit  last_d = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: strobes, grants and completions sampled mid-cycle
    always @(negedge clk) begin
        sb_t e;
        cyc++;
        if (ram_we) begin we_cnt++; last_we_addr = ram_addr; last_we_data = ram_wdata; end
        if (ram_re) re_cnt++;
        if (ram_we && ram_re) both_cnt++;
        if (if_done && d_done) dd_cnt++;
        if (if_done || d_done) begin
            if (sb.size() == 0) begin
                chk("unexpected done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("done source", {63'd0, if_done}, {63'd0, e.fetch});
                chk("err", {63'd0, err}, {63'd0, e.err});
                if (e.chk_data) chk("rdata", {32'd0, rdata}, {32'd0, e.data});
                if (gq.size() > 0) chk("latency", 64'(cyc - gq.pop_front()), 64'(e.lat));
            end
        end
        if (if_gnt || d_gnt) begin
            gq.push_back(cyc);
            gnt_log.push_back(cyc);
        end
    end

    // Expected result in the order grants should occur
    task automatic exp_push(input bit f, input bit we, input logic [31:0] a, input logic [31:0] wd);
        sb_t e;
        e.fetch = f;
        e.err   = (a[31:8] != 24'd0);
        if (e.err) begin
            e.chk_data = 1'b1; e.data = '0; e.lat = 1;
        end else if (!f && we) begin
            e.chk_data = 1'b0; e.data = '0; e.lat = 1;
            ref_mem[a[7:0]] = wd;
        end else begin
            e.chk_data = 1'b1; e.data = ref_mem[a[7:0]]; e.lat = 2;
        end
        sb.push_back(e);
        last_d = !f;
    endtask

    task automatic drive(input bit f, input bit we, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        @(posedge clk); #1;
        if (f) begin if_req = 1'b1; if_addr = a; end
        else begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
        do begin @(negedge clk); n++; end while (!(f ? if_gnt : d_gnt) && n < 60);
        if (!(f ? if_gnt : d_gnt)) chk("gnt timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (f) if_req = 1'b0; else d_req = 1'b0;
    endtask

    task automatic req(input bit f, input bit we, input logic [31:0] a, input logic [31:0] wd);
        exp_push(f, we, a, wd);
        drive(f, we, a, wd);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic contend(input logic [31:0] da, input logic [31:0] fa);
        int k;
        k = gnt_log.size();
        if (last_d) begin exp_push(1'b1, 1'b0, fa, '0); exp_push(1'b0, 1'b0, da, '0); end
        else        begin exp_push(1'b0, 1'b0, da, '0); exp_push(1'b1, 1'b0, fa, '0); end
        fork
            drive(1'b0, 1'b0, da, '0);
            drive(1'b1, 1'b0, fa, '0);
        join
        drain();
        if (gnt_log.size() >= k + 2) chk("contend spacing", 64'(gnt_log[k+1] - gnt_log[k]), 64'd3);
        else chk("contend grants", 64'(gnt_log.size() - k), 64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int w0, r0, k, n;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
            ref_mem[i] = mem[i];
        end
        mem[8'h0D] = 32'h1991_8000;
        ref_mem[8'h0D] = 32'h1991_8000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ctrl", {58'd0, if_gnt, if_done, d_gnt, d_done, err, busy}, 64'd0);
        chk("rst rdata", {32'd0, rdata}, 64'd0);
        chk("rst ram", {22'd0, ram_addr, ram_wdata, ram_we, ram_re}, 64'd0);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Store then load
        w0 = we_cnt; r0 = re_cnt;
        req(1'b0, 1'b1, 32'h52, 32'h2F);
        drain();
        chk("store we pulses", 64'(we_cnt - w0), 64'd1);
        chk("store addr", {56'd0, last_we_addr}, 64'h52);
        chk("store data", {32'd0, last_we_data}, 64'h2F);
        req(1'b0, 1'b0, 32'h52, '0);
        drain();
        chk("load re pulses", 64'(re_cnt - r0), 64'd1);

        // Fetch from preloaded word
        req(1'b1, 1'b0, 32'h0D, '0);
        drain();

        // Contention, first pair
        contend(32'h34, 32'h00);

        // Out of range
        w0 = we_cnt; r0 = re_cnt;
        req(1'b0, 1'b0, 32'h100, '0);
        drain();
        req(1'b1, 1'b0, 32'hFFFF_FFFF, '0);
        drain();
        chk("oor strobes", 64'((we_cnt - w0) + (re_cnt - r0)), 64'd0);

        // Reset during WAIT_R
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h52;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_gnt && n < 60);
        chk("rst-test gnt", {63'd0, d_gnt}, 64'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("busy in wait_r", {63'd0, busy}, 64'd1);
        #1 clr_n = 1'b0;
        #1;
        chk("async rst ctrl", {58'd0, if_gnt, if_done, d_gnt, d_done, err, busy}, 64'd0);
        chk("async rst rdata", {32'd0, rdata}, 64'd0);
        chk("async rst ram", {22'd0, ram_addr, ram_wdata, ram_we, ram_re}, 64'd0);
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        gq.delete();
        last_d = 1'b1;
        repeat (4) @(negedge clk);
        req(1'b0, 1'b0, 32'h52, '0);
        drain();

        // Contention, second pair: order flips
        contend(32'h34, 32'h00);

        // Back-to-back stores with req held high
        w0 = we_cnt;
        k = gnt_log.size();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_addr  = 32'h60 + i;
            d_wdata = 32'hC0DE_0000 + i;
            exp_push(1'b0, 1'b1, d_addr, d_wdata);
            n = 0;
            do begin @(negedge clk); n++; end while (!d_gnt && n < 60);
            if (!d_gnt) chk("b2b gnt timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        d_req = 1'b0;
        drain();
        chk("b2b we pulses", 64'(we_cnt - w0), 64'd3);
        if (gnt_log.size() >= k + 3) begin
            chk("b2b spacing 0", 64'(gnt_log[k+1] - gnt_log[k]), 64'd2);
            chk("b2b spacing 1", 64'(gnt_log[k+2] - gnt_log[k+1]), 64'd2);
        end else begin
            chk("b2b grants", 64'(gnt_log.size() - k), 64'd3);
        end
        for (int i = 0; i < 3; i++) begin
            req(1'b0, 1'b0, 32'h60 + i, '0);
            drain();
        end

        chk("we/re overlap", 64'(both_cnt), 64'd0);
        chk("done overlap", 64'(dd_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
